// File: rtl/loopback_checker_pkg.sv
// Shared types and helpers for the pad loopback checker: FSM states,
// LFSR feedback taps and the golden model of the loopback function.
package loopback_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Feedback taps s[7], s[5], s[4], s[3] of the 8-bit Fibonacci LFSR (period 255).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One shift-left step: the new lsb is the XOR of the tapped bits.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    // Expected loopback response: low seven bits mirror s[0], bit 7 is the AND of the top nibble.
    function automatic logic [7:0] loopback_model(input logic [7:0] s);
        return {&s[7:4], {7{s[0]}}};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and single-step advance.
module lfsr8
    import loopback_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_reg;

    // Load has priority over advance so a restart always begins from the seed.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            q_reg <= seed;
        end else if (advance) begin
            q_reg <= lfsr_step(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/loopback_checker.sv
// Stimulus/response checker for the pad loopback: issues LFSR vectors,
// delays the golden response by LATENCY cycles and compares it to resp_in.
module loopback_checker
    import loopback_checker_pkg::*;
#(
    parameter int         LATENCY   = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n_vectors,
    output logic [7:0]  stim_out,
    input  logic [7:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic        first_err_valid,
    output logic [7:0]  first_err_vec
);

    state_t      state_reg, state_next;
    logic [15:0] remaining_reg, remaining_next;
    logic [7:0]  stim_reg, stim_next;
    logic [15:0] err_count_reg;
    logic        first_err_valid_reg;
    logic [7:0]  first_err_vec_reg;

    logic        lfsr_load, lfsr_advance;
    logic [7:0]  lfsr_q;
    logic        push_valid;
    logic        clear_stats;
    logic        pending;
    logic        mismatch;

    // Delay line: stage 0 is the head, stage LATENCY-1 is the tail being compared.
    logic [LATENCY-1:0]       dl_valid;
    logic [LATENCY-1:0][7:0]  dl_exp;
    logic [LATENCY-1:0][7:0]  dl_vec;

    lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_advance),
        .seed    (LFSR_SEED),
        .q       (lfsr_q)
    );

    // State, vector counter and registered stimulus output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            stim_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            stim_reg      <= stim_next;
        end
    end

    // Next-state logic; stim_next is the vector that will be on the pins next cycle.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        stim_next      = '0;
        lfsr_load      = 1'b0;
        lfsr_advance   = 1'b0;
        push_valid     = 1'b0;
        clear_stats    = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_load      = 1'b1;
                    clear_stats    = 1'b1;
                    remaining_next = n_vectors;
                    if (n_vectors == 16'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        stim_next  = LFSR_SEED;
                    end
                end
            end
            RUN: begin
                // The vector currently on stim_out is pushed; the LFSR moves to the next one.
                push_valid     = 1'b1;
                lfsr_advance   = 1'b1;
                remaining_next = remaining_reg - 16'd1;
                if (remaining_reg == 16'd1) begin
                    state_next = DRAIN;
                end else begin
                    stim_next = lfsr_step(lfsr_q);
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Entries still in flight after this cycle's shift (everything except the tail).
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pending = pending | dl_valid[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_dl
            logic       valid_in;
            logic [7:0] exp_in;
            logic [7:0] vec_in;
            logic       valid_reg;
            logic [7:0] exp_reg;
            logic [7:0] vec_reg;

            if (gi == 0) begin : g_head
                assign valid_in = push_valid;
                assign exp_in   = loopback_model(stim_reg);
                assign vec_in   = stim_reg;
            end else begin : g_body
                assign valid_in = dl_valid[gi-1];
                assign exp_in   = dl_exp[gi-1];
                assign vec_in   = dl_vec[gi-1];
            end

            // One delay-line stage; it shifts every cycle and bubbles are valid=0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    exp_reg   <= '0;
                    vec_reg   <= '0;
                end else begin
                    valid_reg <= valid_in;
                    exp_reg   <= exp_in;
                    vec_reg   <= vec_in;
                end
            end

            assign dl_valid[gi] = valid_reg;
            assign dl_exp[gi]   = exp_reg;
            assign dl_vec[gi]   = vec_reg;
        end
    endgenerate

    assign mismatch = dl_valid[LATENCY-1] && (resp_in != dl_exp[LATENCY-1]);

    // Error bookkeeping: saturating count and capture of the first failing stimulus.
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            err_count_reg       <= '0;
            first_err_valid_reg <= 1'b0;
            first_err_vec_reg   <= '0;
        end else if (mismatch) begin
            if (err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
            if (!first_err_valid_reg) begin
                first_err_valid_reg <= 1'b1;
                first_err_vec_reg   <= dl_vec[LATENCY-1];
            end
        end
    end

    assign stim_out        = stim_reg;
    assign busy            = (state_reg == RUN) || (state_reg == DRAIN);
    assign done            = (state_reg == DONE);
    assign pass            = (state_reg == DONE) && (err_count_reg == 16'd0);
    assign err_count       = err_count_reg;
    assign first_err_valid = first_err_valid_reg;
    assign first_err_vec   = first_err_vec_reg;

endmodule

// File: tb/tb_loopback_checker.sv
// Directed bench for loopback_checker: a bench-side pad loopback with
// programmable delay and a stuck-at-0 option on bit 7 feeds resp_in.
module tb_loopback_checker;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n_vectors;
    logic [7:0]  stim_out;
    logic [7:0]  resp_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [7:0]  first_err_vec;

    int errors = 0;
    int checks = 0;

    int         loop_delay = 2;
    bit         stuck7 = 1'b0;
    logic [7:0] pipe [8];

    loopback_checker #(.LATENCY(LAT), .LFSR_SEED(8'hA5)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .n_vectors       (n_vectors),
        .stim_out        (stim_out),
        .resp_in         (resp_in),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec)
    );

    always #5 clk = ~clk;

    // Pad loopback behaviour as seen from the pins.
    function automatic logic [7:0] pad_model(input logic [7:0] s);
        logic [7:0] r;
        r[6:0] = s[0] ? 7'h7F : 7'h00;
        r[7]   = (s[7:4] == 4'hF);
        return r;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= pad_model(stim_out);
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    always_comb resp_in = stuck7 ? {1'b0, pipe[loop_delay-1][6:0]} : pipe[loop_delay-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        int         dly;
        bit         stuck;
        bit         poke;
        bit         exp_pass;
        int         exp_err;
        bit         exp_fv;
        logic [7:0] exp_fev;
    } vec_t;

    vec_t tbl [7];

    task automatic run_case(input int idx, input vec_t v);
        int         cyc;
        int         exp_lat;
        logic [7:0] s0, s1, s2;
        loop_delay = v.dly;
        stuck7     = v.stuck;
        n_vectors  = 16'(v.n);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        s0    = stim_out;
        s1    = 8'h00;
        s2    = 8'h00;
        check("clear_err", 32'(err_count), 32'd0);
        check("clear_fv", 32'(first_err_valid), 32'd0);
        while (done !== 1'b1 && cyc < 1000) begin
            start = (v.poke && (cyc == 5 || cyc == v.n + LAT)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) s1 = stim_out;
            if (cyc == 3) s2 = stim_out;
        end
        start   = 1'b0;
        exp_lat = (v.n == 0) ? 1 : v.n + LAT + 1;
        $display("run %0d: n=%0d dly=%0d stuck=%0d poke=%0d -> cycles=%0d pass=%0b err=%0d fv=%0b fev=%02h",
                 idx, v.n, v.dly, v.stuck, v.poke, cyc, pass, err_count, first_err_valid, first_err_vec);
        check("done_latency", 32'(cyc), 32'(exp_lat));
        check("stim_first", 32'(s0), (v.n == 0) ? 32'h00 : 32'hA5);
        if (v.n >= 3) begin
            check("stim_second", 32'(s1), 32'h4A);
            check("stim_third", 32'(s2), 32'h95);
        end
        check("pass", 32'(pass), 32'(v.exp_pass));
        check("err_count", 32'(err_count), 32'(v.exp_err));
        check("first_err_valid", 32'(first_err_valid), 32'(v.exp_fv));
        check("first_err_vec", 32'(first_err_vec), 32'(v.exp_fev));
        check("busy_in_done", 32'(busy), 32'd0);
        check("stim_in_done", 32'(stim_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("done_held", 32'(done), 32'd1);
        check("pass_held", 32'(pass), 32'(v.exp_pass));
    endtask

    initial begin
        //           n    dly stuck poke pass err fv fev
        tbl[0] = '{255, 2, 1'b0, 1'b0, 1'b1, 0,  1'b0, 8'h00};
        tbl[1] = '{255, 2, 1'b1, 1'b0, 1'b0, 16, 1'b1, 8'hF7};
        tbl[2] = '{16,  3, 1'b0, 1'b0, 1'b0, 10, 1'b1, 8'hA5};
        tbl[3] = '{0,   2, 1'b0, 1'b0, 1'b1, 0,  1'b0, 8'h00};
        tbl[4] = '{25,  2, 1'b1, 1'b1, 1'b0, 1,  1'b1, 8'hF7};
        tbl[5] = '{24,  2, 1'b1, 1'b0, 1'b1, 0,  1'b0, 8'h00};
        tbl[6] = '{16,  2, 1'b0, 1'b1, 1'b1, 0,  1'b0, 8'h00};

        rst       = 1'b1;
        start     = 1'b0;
        n_vectors = 16'd0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_stim", 32'(stim_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_err", 32'(err_count), 32'd0);
        check("reset_fv", 32'(first_err_valid), 32'd0);
        check("reset_fev", 32'(first_err_vec), 32'd0);

        for (int k = 0; k < 7; k++) run_case(k, tbl[k]);

        // Reset in the tenth RUN cycle of an erroring run, then a clean rerun from IDLE.
        loop_delay = 3;
        stuck7     = 1'b0;
        n_vectors  = 16'd255;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset mid-run: stim=%02h busy=%0b done=%0b err=%0d fv=%0b",
                 stim_out, busy, done, err_count, first_err_valid);
        check("midrst_stim", 32'(stim_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pass", 32'(pass), 32'd0);
        check("midrst_err", 32'(err_count), 32'd0);
        check("midrst_fv", 32'(first_err_valid), 32'd0);
        check("midrst_fev", 32'(first_err_vec), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle_done", 32'(done), 32'd0);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        run_case(7, tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
